// File: rtl/micro_control_unit.sv
// Microprogrammed multicycle controller for the ARM-subset datapath: a 10-word
// control store, two Instr-indexed dispatch tables and an NZCV condition unit.
module micro_control_unit #(
  parameter int UPC_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic [3:0]       ALUFlags,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic [1:0]       RegSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       ALUControl,
  output logic [UPC_W-1:0] uPC
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB    = 4'd8, S_BRANCH = 4'd9
  } state_e;

  typedef struct packed {
    logic       pc_update;
    logic       ir_write;
    logic       ureg_w;
    logic       umem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] next_sel;
    state_e     next_adr;
  } uword_t;

  localparam logic [1:0] SEL_ADR   = 2'b00;
  localparam logic [1:0] SEL_D1    = 2'b01;
  localparam logic [1:0] SEL_D2    = 2'b10;
  localparam logic [1:0] SEL_FETCH = 2'b11;

  // Unencoded addresses fall to the default word: no enables, back to FETCH.
  function automatic uword_t rom(input state_e a);
    uword_t w;
    w          = '0;
    w.next_sel = SEL_FETCH;
    w.next_adr = S_FETCH;
    case (a)
      S_FETCH: begin
        w.ir_write = 1'b1; w.pc_update = 1'b1; w.alu_src_a = 2'b01;
        w.alu_src_b = 2'b10; w.result_src = 2'b10;
        w.next_sel = SEL_ADR; w.next_adr = S_DECODE;
      end
      S_DECODE: begin
        w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.result_src = 2'b10;
        w.next_sel = SEL_D1;
      end
      S_MEMADR:   begin w.alu_src_b = 2'b01; w.next_sel = SEL_D2; end
      S_MEMREAD:  begin w.adr_src = 1'b1; w.next_sel = SEL_ADR; w.next_adr = S_MEMWB; end
      S_MEMWB:    begin w.result_src = 2'b01; w.ureg_w = 1'b1; end
      S_MEMWRITE: begin w.adr_src = 1'b1; w.umem_w = 1'b1; end
      S_EXECR:    begin w.alu_op = 1'b1; w.next_sel = SEL_ADR; w.next_adr = S_ALUWB; end
      S_EXECI: begin
        w.alu_op = 1'b1; w.alu_src_b = 2'b01;
        w.next_sel = SEL_ADR; w.next_adr = S_ALUWB;
      end
      S_ALUWB:    begin w.ureg_w = 1'b1; end
      S_BRANCH:   begin w.alu_src_b = 2'b01; w.result_src = 2'b10; w.branch = 1'b1; end
      default:    begin w.next_sel = SEL_FETCH; end
    endcase
    return w;
  endfunction

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = c;
      4'b0011: r = ~c;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = c & ~z;
      4'b1001: r = ~c | z;
      4'b1010: r = ~(n ^ v);
      4'b1011: r = n ^ v;
      4'b1100: r = ~z & ~(n ^ v);
      4'b1101: r = z | (n ^ v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_e     upc_q, upc_d;
  logic [3:0] flags_q, flags_d;
  logic       condex_q, condex_d;
  uword_t     uw_s;
  logic [1:0] op_s, flag_w_s, alu_dec_s;
  logic [3:0] cmd_s;
  logic       condex_s, no_write_s, in_exec_s, in_aluwb_s, cond_gate_s;
  logic       unused_instr_s;

  assign uw_s           = rom(upc_q);
  assign op_s           = Instr[27:26];
  assign cmd_s          = Instr[24:21];
  assign condex_s       = cond_eval(Instr[31:28], flags_q);
  assign in_exec_s      = (upc_q == S_EXECR) || (upc_q == S_EXECI);
  assign in_aluwb_s     = (upc_q == S_ALUWB);
  assign unused_instr_s = ^Instr[19:0];

  // ALU command decode; non-writing commands are flagged for ALUWB suppression.
  always_comb begin
    alu_dec_s  = 2'b00;
    no_write_s = 1'b0;
    case (cmd_s)
      4'b0100: alu_dec_s = 2'b00;
      4'b0010: alu_dec_s = 2'b01;
      4'b0000: alu_dec_s = 2'b10;
      4'b1100: alu_dec_s = 2'b11;
      4'b1010: begin alu_dec_s = 2'b01; no_write_s = 1'b1; end
      default: begin alu_dec_s = 2'b00; no_write_s = 1'b1; end
    endcase
    flag_w_s = {Instr[20], Instr[20] & ((cmd_s == 4'b0100) || (cmd_s == 4'b0010) ||
                                        (cmd_s == 4'b1010))};
  end

  // Micro-PC sequencing: explicit address, dispatch tables or return to FETCH.
  always_comb begin
    upc_d = S_FETCH;
    case (uw_s.next_sel)
      SEL_ADR: upc_d = uw_s.next_adr;
      SEL_D1: begin
        case (op_s)
          2'b00:   upc_d = Instr[25] ? S_EXECI : S_EXECR;
          2'b01:   upc_d = S_MEMADR;
          2'b10:   upc_d = S_BRANCH;
          default: upc_d = S_FETCH;
        endcase
      end
      SEL_D2:  upc_d = Instr[20] ? S_MEMREAD : S_MEMWRITE;
      default: upc_d = S_FETCH;
    endcase
  end

  // Flags load on the EXEC edge; CondEx is snapshotted there so ALUWB sees pre-update flags.
  always_comb begin
    flags_d  = flags_q;
    condex_d = condex_q;
    if (in_exec_s) begin
      condex_d = condex_s;
      if (condex_s && flag_w_s[1]) flags_d[3:2] = ALUFlags[3:2];
      else                         flags_d[3:2] = flags_q[3:2];
      if (condex_s && flag_w_s[0]) flags_d[1:0] = ALUFlags[1:0];
      else                         flags_d[1:0] = flags_q[1:0];
    end else begin
      condex_d = condex_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc_q    <= S_FETCH;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      upc_q    <= upc_d;
      flags_q  <= flags_d;
      condex_q <= condex_d;
    end
  end

  assign cond_gate_s = in_aluwb_s ? condex_q : condex_s;

  assign PCWrite    = reset & (uw_s.pc_update | (uw_s.branch & condex_s));
  assign IRWrite    = reset & uw_s.ir_write;
  assign RegWrite   = reset & uw_s.ureg_w & cond_gate_s & ~(in_aluwb_s & no_write_s);
  assign MemWrite   = reset & uw_s.umem_w & condex_s;
  assign AdrSrc     = uw_s.adr_src;
  assign ALUSrcA    = uw_s.alu_src_a;
  assign ALUSrcB    = uw_s.alu_src_b;
  assign ResultSrc  = uw_s.result_src;
  assign ALUControl = uw_s.alu_op ? alu_dec_s : 2'b00;
  assign RegSrc     = {op_s == 2'b01, op_s == 2'b10};
  assign ImmSrc     = op_s;
  assign uPC        = UPC_W'(upc_q);

endmodule

// File: tb/tb_micro_control_unit.sv
// Self-checking bench for micro_control_unit: directed vector table, reset
// corner sequences and random instructions against a behavioural model.
module tb_micro_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic [3:0]  uPC;

  int checks = 0;
  int errors = 0;

  micro_control_unit #(.UPC_W(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .uPC(uPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  af;
    int          len;
    logic [23:0] seq;  // uPC per cycle, first cycle in the top nibble
    logic [23:0] we;   // {PCWrite,IRWrite,RegWrite,MemWrite} per cycle
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ARM condition semantics: pairs share a base test, odd codes invert it.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  function automatic logic [1:0] alu_m(input logic [3:0] cmd);
    if (cmd == 4'b0100) return 2'b00;
    if (cmd == 4'b0010 || cmd == 4'b1010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit writes_m(input logic [3:0] cmd);
    return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
  endfunction

  // {mask, value} over {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} for fields each state defines.
  function automatic logic [13:0] sel_spec(input logic [3:0] s);
    case (s)
      4'd0:    return {7'b1111111, 7'b0011010};
      4'd1:    return {7'b0111111, 7'b0011010};
      4'd2:    return {7'b0111100, 7'b0000100};
      4'd3:    return {7'b1000011, 7'b1000000};
      4'd4:    return {7'b0000011, 7'b0000001};
      4'd5:    return {7'b1000011, 7'b1000000};
      4'd6:    return {7'b0111100, 7'b0000000};
      4'd7:    return {7'b0111100, 7'b0000100};
      4'd8:    return {7'b0000011, 7'b0000000};
      4'd9:    return {7'b0111111, 7'b0000110};
      default: return 14'd0;
    endcase
  endfunction

  task automatic cycle_check(input string tag, input logic [3:0] s, input logic [3:0] we,
                             input logic [31:0] ins);
    logic [13:0] ms;
    logic [6:0]  sel;
    ms  = sel_spec(s);
    sel = {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc};
    chk({tag, ":upc"}, uPC, s);
    chk({tag, ":we"}, {PCWrite, IRWrite, RegWrite, MemWrite}, we);
    chk({tag, ":imm"}, ImmSrc, ins[27:26]);
    chk({tag, ":regsrc"}, RegSrc, {ins[27:26] == 2'b01, ins[27:26] == 2'b10});
    chk({tag, ":sel"}, sel & ms[13:7], ms[6:0]);
    chk({tag, ":aluctl"}, ALUControl,
        (s == 4'd6 || s == 4'd7) ? alu_m(ins[24:21]) : 2'b00);
  endtask

  // Starts in FETCH; ends in the FETCH that follows (last table entry).
  task automatic run_seq(input string tag, input logic [31:0] ins, input logic [3:0] af,
                         input int len, input logic [23:0] seq, input logic [23:0] we);
    Instr = ins; ALUFlags = af; #1;
    for (int k = 0; k < len; k++) begin
      cycle_check($sformatf("%s.c%0d", tag, k), seq[23-4*k -: 4], we[23-4*k -: 4], ins);
      if (k < len - 1) begin
        @(posedge clk); @(negedge clk); #1;
      end
    end
  endtask

  logic [31:0] ins;
  logic [3:0]  af, fm, exp_we;
  logic [3:0]  st;
  bit          ce_exec;
  int          path[$];

  initial begin
    tbl[0]  = '{32'hE0821003, 4'h0, 5, 24'h016800, 24'hC002C0}; // ADD
    tbl[1]  = '{32'hE5910004, 4'h0, 6, 24'h012340, 24'hC0002C}; // LDR
    tbl[2]  = '{32'hE3500000, 4'h4, 5, 24'h017800, 24'hC000C0}; // CMP -> Z=1
    tbl[3]  = '{32'h0A000002, 4'h0, 4, 24'h019000, 24'hC08C00}; // BEQ taken
    tbl[4]  = '{32'h15810000, 4'h0, 5, 24'h012500, 24'hC000C0}; // STRNE, Z=1
    tbl[5]  = '{32'hE3500000, 4'h0, 5, 24'h017800, 24'hC000C0}; // CMP -> Z=0
    tbl[6]  = '{32'h0A000002, 4'h0, 4, 24'h019000, 24'hC00C00}; // BEQ not taken
    tbl[7]  = '{32'h15810000, 4'h0, 5, 24'h012500, 24'hC001C0}; // STRNE, Z=0
    tbl[8]  = '{32'hEC000000, 4'h0, 3, 24'h010000, 24'hC0C000}; // op 11 NOP
    tbl[9]  = '{32'hE3500000, 4'h4, 5, 24'h017800, 24'hC000C0}; // CMP -> Z=1
    tbl[10] = '{32'h00921003, 4'h0, 5, 24'h016800, 24'hC002C0}; // ADDEQS clears Z, still writes
    tbl[11] = '{32'h0A000002, 4'h0, 4, 24'h019000, 24'hC00C00}; // BEQ sees Z=0

    reset = 1'b0; Instr = 32'd0; ALUFlags = 4'd0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_upc", uPC, 4'd0);
      chk("rst_we", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'h0);
    end
    reset = 1'b1; #1;
    chk("rel_upc", uPC, 4'd0);
    chk("rel_we", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'hC);

    for (int i = 0; i < 12; i++)
      run_seq($sformatf("vec%0d", i), tbl[i].instr, tbl[i].af, tbl[i].len, tbl[i].seq, tbl[i].we);

    // STRNE with Z=0 aborted by reset in MEMADR: no store may follow.
    Instr = 32'h15810000; ALUFlags = 4'h0; #1;
    chk("abort_upc0", uPC, 4'd0);
    @(posedge clk); @(negedge clk); #1;
    chk("abort_upc1", uPC, 4'd1);
    @(posedge clk); @(negedge clk); #1;
    chk("abort_upc2", uPC, 4'd2);
    reset = 1'b0; #1;
    chk("abort_async_upc", uPC, 4'd0);
    chk("abort_async_we", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_hold_memw", MemWrite, 1'b0);
      chk("abort_hold_upc", uPC, 4'd0);
    end
    @(negedge clk); reset = 1'b1; #1;
    chk("abort_rel_we", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'hC);

    // Reset clears a set Z flag: BEQ afterwards must not branch.
    run_seq("clr_cmp", 32'hE3500000, 4'h4, 5, 24'h017800, 24'hC000C0);
    reset = 1'b0; #1;
    chk("clr_upc", uPC, 4'd0);
    @(negedge clk); reset = 1'b1; #1;
    run_seq("clr_beq", 32'h0A000002, 4'h0, 4, 24'h019000, 24'hC00C00);

    // Random instructions against the behavioural model; flags are zero here.
    fm = 4'h0;
    ce_exec = 1'b0;
    for (int it = 0; it < 300; it++) begin
      ins = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: ins[24:21] = 4'b0100;
          1: ins[24:21] = 4'b0010;
          2: ins[24:21] = 4'b0000;
          3: ins[24:21] = 4'b1100;
          default: ins[24:21] = 4'b1010;
        endcase
      end
      af = 4'($urandom_range(0, 15));
      Instr = ins; ALUFlags = af; #1;
      path.delete();
      path.push_back(0);
      path.push_back(1);
      case (ins[27:26])
        2'b00: begin path.push_back(ins[25] ? 7 : 6); path.push_back(8); end
        2'b01: begin
          path.push_back(2);
          if (ins[20]) begin path.push_back(3); path.push_back(4); end
          else path.push_back(5);
        end
        2'b10: path.push_back(9);
        default: ;
      endcase
      foreach (path[k]) begin
        st = 4'(path[k]);
        case (st)
          4'd0: exp_we = 4'b1100;
          4'd4: exp_we = {2'b00, cond_ok(ins[31:28], fm), 1'b0};
          4'd5: exp_we = {3'b000, cond_ok(ins[31:28], fm)};
          4'd8: exp_we = {2'b00, ce_exec && writes_m(ins[24:21]), 1'b0};
          4'd9: exp_we = {cond_ok(ins[31:28], fm), 3'b000};
          default: exp_we = 4'b0000;
        endcase
        cycle_check($sformatf("rnd%0d.c%0d", it, k), st, exp_we, ins);
        if (st == 4'd6 || st == 4'd7) begin
          ce_exec = cond_ok(ins[31:28], fm);
          if (ce_exec && ins[20]) begin
            fm[3:2] = af[3:2];
            if (ins[24:21] == 4'b0100 || ins[24:21] == 4'b0010 || ins[24:21] == 4'b1010)
              fm[1:0] = af[1:0];
          end
        end
        @(posedge clk); @(negedge clk); #1;
      end
    end
    chk("rnd_end_upc", uPC, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_control_unit.md
# micro_control_unit

- Microprogrammed multicycle controller for the ARM-subset datapath. It sits directly upstream of the datapath and drives every datapath select and enable.
- Sequencing comes from a 10-word control-store ROM plus two dispatch tables indexed by `Instr`.
- A condition unit holds the NZCV flags register and gates architectural writes.
- Also produces `MemWrite` for the unified instruction/data memory.

## Interface
Parameters:
- `UPC_W`, 4, micro-PC width (10 microwords used, 0–9).

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low.
- `Instr` input 32: instruction register contents from datapath.
- `ALUFlags` input 4: {N,Z,C,V} from the datapath ALU, combinational.
- `PCWrite` output 1: PC register enable.
- `IRWrite` output 1: instruction register enable.
- `RegWrite` output 1: register-file write enable.
- `MemWrite` output 1: memory write strobe.
- `AdrSrc` output 1: memory address select (0 = PC, 1 = Result).
- `RegSrc` output 2: [0] RA1 = R15, [1] RA2 = Instr[15:12].
- `ALUSrcA` output 2: 00 = A, 01 = PC.
- `ALUSrcB` output 2: 00 = shifted RD2, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` output 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc` output 2: extend mode, equal to Instr[27:26].
- `ALUControl` output 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `uPC` output UPC_W: current microword address (debug/verification).

## Operation
Microword fields:
- Control: PCUpdate, IRWrite, uRegW, uMemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc.
- Sequencing: NextSel (00 explicit NextAdr, 01 dispatch1, 10 dispatch2, 11 return to FETCH) and NextAdr.

States and datapath controls (ALU ADD unless ALUOp):
- 0 FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 01, ALUSrcB 10, ResultSrc 10, PCUpdate 1. Next is DECODE.
- 1 DECODE: ALUSrcA 01, ALUSrcB 10, ResultSrc 10. Next is dispatch1.
- 2 MEMADR: ALUSrcA 00, ALUSrcB 01. Next is dispatch2.
- 3 MEMREAD: AdrSrc 1, ResultSrc 00. Next is MEMWB.
- 4 MEMWB: ResultSrc 01, uRegW. Next is FETCH.
- 5 MEMWRITE: AdrSrc 1, ResultSrc 00, uMemW. Next is FETCH.
- 6 EXECUTER: ALUSrcA 00, ALUSrcB 00, ALUOp. Next is ALUWB.
- 7 EXECUTEI: ALUSrcA 00, ALUSrcB 01, ALUOp. Next is ALUWB.
- 8 ALUWB: ResultSrc 00, uRegW. Next is FETCH.
- 9 BRANCH: ALUSrcA 00, ALUSrcB 01, ResultSrc 10, Branch. Next is FETCH.

Dispatch tables:
- Dispatch1 on Op = Instr[27:26]:
  - 00 with I (Instr[25]) = 0 goes to EXECUTER; I = 1 goes to EXECUTEI.
  - 01 goes to MEMADR.
  - 10 goes to BRANCH.
  - 11 goes to FETCH (treated as NOP).
- Dispatch2 on L = Instr[20]: 1 goes to MEMREAD, 0 goes to MEMWRITE.

Combinational decode from Instr, valid in every state:
- RegSrc = {Op == 01, Op == 10}.
- ImmSrc = Op.

ALU decode:
- ALUOp = 0 gives ALUControl 00.
- ALUOp = 1 decodes cmd = Instr[24:21]:
  - 0100 ADD gives 00.
  - 0010 SUB gives 01.
  - 0000 AND gives 10.
  - 1100 ORR gives 11.
  - 1010 CMP gives 01 with NoWrite.
  - Any other cmd gives 00 with NoWrite.

Condition unit:
- CondEx is computed from Instr[31:28] and the Flags register: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM; 1110 gives 1; 1111 gives 0.
- FlagW[1] (N,Z) = S.
- FlagW[0] (C,V) = S & cmd ∈ {ADD, SUB, CMP}.
- Flags[3:2] load ALUFlags[3:2] on the edge leaving EXECUTER/EXECUTEI when FlagW[1] & CondEx. Flags[1:0] load likewise under FlagW[0].

Output gating:
- PCWrite = PCUpdate | (Branch & CondEx).
- RegWrite = uRegW & CondEx & ~(ALUWB & NoWrite).
- MemWrite = uMemW & CondEx.

## Timing
- Reset asserted (0): uPC = 0 and Flags = 0 immediately, asynchronously.
- While reset is asserted, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Other outputs show the FETCH word.
- The first rising edge after reset deassertion executes FETCH.
- uPC advances every cycle with no stalls.
- Cycle counts per instruction:
  - Data-processing: 4 (FETCH, DECODE, EXEC, ALUWB).
  - LDR: 5.
  - STR: 4.
  - Branch: 3.
  - Op 11: 2.
- CondEx is evaluated from Flags as held at the start of the cycle. A flag update in EXEC is visible to the ALUWB of the same instruction only for gating of the following instruction. ALUWB gating uses Flags latched before the EXEC edge; a CondEx copy is registered in EXEC.
- Reset mid-instruction aborts immediately and returns to FETCH with Flags cleared. No partial write occurs after assertion.
- An unencoded uPC (10–15) returns to FETCH on the next edge, with all enables 0.

## Test plan
- Reset: hold reset = 0 for 3 cycles, then release. Required: uPC = 0, Flags = 0000, all write enables 0 during reset, then IRWrite = 1 and PCWrite = 1 in the first FETCH.
- ADD R1,R2,R3 (0xE0821003): uPC sequence 0,1,6,8,0. In state 6, ALUControl = 00 and ALUSrcB = 00. In state 8, RegWrite = 1 and ResultSrc = 00.
- LDR R0,[R1,#4] (0xE5910004): uPC sequence 0,1,2,3,4,0. ImmSrc = 01 throughout. In state 3, AdrSrc = 1. In state 4, ResultSrc = 01 and RegWrite = 1.
- CMP R0,#0 (0xE3500000) with ALUFlags = 0100 in state 7: ALUControl = 01, Flags become 0100, RegWrite = 0 in state 8.
- Then BEQ (0x0A000002): uPC sequence 0,1,9. In state 9, PCWrite = 1, RegSrc = 01, ImmSrc = 10. Repeat with Flags = 0000: PCWrite = 0 in state 9.
- STRNE (0x15810000) with Z = 1: uPC sequence 0,1,2,5, MemWrite = 0 throughout. With Z = 0, MemWrite = 1 in state 5. Assert reset during state 2: uPC = 0 at once and MemWrite never pulses.
